// File: rtl/zacore_mem_arbiter_pkg.sv
// Shared types for the zacore memory-port arbiter.
// FSM states, latched request bundle and requester ids.
package zacore_common;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_BUSY,
    DATA_BUSY
  } mem_arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;

  typedef enum logic {
    REQ_FETCH,
    REQ_DATA
  } requester_t;

endpackage

// File: rtl/zacore_mem_arbiter.sv
// Fetch/LSU arbiter for the single memory port.
// Build option ZACORE_MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration.
module zacore_mem_arbiter
  import zacore_common::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_addr,
  output logic        o_fetch_ack,
  output logic [31:0] o_inst_read,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_be,
  output logic        o_data_ack,
  output logic [31:0] o_data_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  mem_arb_state_t state;
  mem_req_t       req_q;
  logic           abort;
  logic           any_req;
  logic           pick_data;
  logic           owner_req;

  assign any_req = i_fetch_req | i_data_req;

`ifdef ZACORE_MEM_ARB_ROUND_ROBIN_EN
  requester_t rr_ptr;

  // On contention, the requester the pointer names wins
  always_comb begin
    pick_data = i_data_req & (~i_fetch_req | (rr_ptr == REQ_DATA));
  end

  // Pointer flips to the other requester after every grant
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr <= REQ_DATA;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= pick_data ? REQ_FETCH : REQ_DATA;
    end
  end
`else
  localparam int CW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_DATA_BURST);

  logic [CW-1:0] burst;

  // Data wins contention until fetch has waited a full burst
  always_comb begin
    pick_data = i_data_req & (~i_fetch_req | (burst != BURST_MAX));
  end

  // Count data grants that overtook a waiting fetch
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      burst <= '0;
    end else if (state == IDLE) begin
      if (!i_fetch_req || !pick_data) begin
        burst <= '0;
      end else if (burst != BURST_MAX) begin
        burst <= burst + 1'b1;
      end
    end
  end
`endif

  // Request line of whoever currently owns the port
  always_comb begin
    owner_req = (state == DATA_BUSY) ? i_data_req : i_fetch_req;
  end

  assign o_mem_we    = req_q.we;
  assign o_mem_addr  = req_q.addr;
  assign o_mem_wdata = req_q.wdata;
  assign o_mem_be    = req_q.be;

  assign o_inst_read  = i_mem_rdata;
  assign o_data_rdata = i_mem_rdata;

  assign o_fetch_ack = i_mem_ack & (state == FETCH_BUSY)
                     & i_fetch_req & ~abort;
  assign o_data_ack  = i_mem_ack & (state == DATA_BUSY)
                     & i_data_req & ~abort;

  // Grant, latch the winner's fields, hold the port until memory acks
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_mem_req <= 1'b0;
      req_q     <= '0;
      abort     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          abort <= 1'b0;
          if (any_req) begin
            o_mem_req <= 1'b1;
            if (pick_data) begin
              state <= DATA_BUSY;
              req_q <= '{we: i_data_we, addr: i_data_addr,
                         wdata: i_data_wdata, be: i_data_be};
            end else begin
              state <= FETCH_BUSY;
              req_q <= '{we: 1'b0, addr: i_fetch_addr,
                         wdata: 32'h0, be: 4'hF};
            end
          end
        end
        FETCH_BUSY, DATA_BUSY: begin
          if (i_mem_ack) begin
            state     <= IDLE;
            o_mem_req <= 1'b0;
          end else if (!owner_req) begin
            abort <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zacore_mem_arbiter.sv
// Bench for zacore_mem_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the port.
module tb_zacore_mem_arbiter;

  localparam int MAXB = 4;

  logic        clk = 0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] inst_read;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_be;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  zacore_mem_arbiter #(.MAX_DATA_BURST(MAXB)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
    .o_fetch_ack(fetch_ack), .o_inst_read(inst_read),
    .i_data_req(data_req), .i_data_we(data_we),
    .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .i_data_be(data_be), .o_data_ack(data_ack),
    .o_data_rdata(data_rdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_be(mem_be), .i_mem_ack(mem_ack),
    .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: one outstanding memory transaction owned by F (0) or D (1)
  bit          m_busy;
  bit          m_owner;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  bit          m_drop;
  int          m_overtakes;
  bit          m_pref_data;
  bit          grants[$];
  bit          ack_f, ack_d;
  int          n_ack_f, n_ack_d;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_drop = 0; m_overtakes = 0; m_pref_data = 1;
  endfunction

  // Compare this cycle's outputs, then advance the model one clock
  task automatic step();
    bit win_data;
    #1;
    check("mem_req", mem_req, m_busy);
    if (m_busy) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_we", mem_we, m_we);
      check("mem_wdata", mem_wdata, m_wdata);
      check("mem_be", mem_be, m_be);
    end
    ack_f = m_busy && !m_owner && mem_ack && fetch_req && !m_drop;
    ack_d = m_busy && m_owner && mem_ack && data_req && !m_drop;
    check("fetch_ack", fetch_ack, ack_f);
    check("data_ack", data_ack, ack_d);
    if (ack_f) check("inst_read", inst_read, mem_rdata);
    if (ack_d) check("data_rdata", data_rdata, mem_rdata);
    n_ack_f += ack_f;
    n_ack_d += ack_d;
    if (rst) begin
      model_reset();
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0; m_drop = 0;
      end else if (!(m_owner ? data_req : fetch_req)) begin
        m_drop = 1;
      end
    end else begin
      if (fetch_req || data_req) begin
`ifdef ZACORE_MEM_ARB_ROUND_ROBIN_EN
        win_data = data_req && (!fetch_req || m_pref_data);
        m_pref_data = !win_data;
`else
        win_data = data_req && (!fetch_req || m_overtakes < MAXB);
`endif
        m_busy = 1; m_owner = win_data;
        if (win_data) begin
          m_we = data_we; m_addr = data_addr;
          m_wdata = data_wdata; m_be = data_be;
        end else begin
          m_we = 0; m_addr = fetch_addr; m_wdata = 0; m_be = 4'hF;
        end
        grants.push_back(win_data);
      end
      if (fetch_req && win_data && (fetch_req || data_req))
        m_overtakes = (m_overtakes < MAXB) ? m_overtakes + 1 : MAXB;
      else
        m_overtakes = 0;
    end
    @(negedge clk);
  endtask

  bit exp3[6];
  bit drew;

  initial begin
    rst = 1; fetch_req = 0; data_req = 0; mem_ack = 0;
    fetch_addr = 0; data_we = 0; data_addr = 0;
    data_wdata = 0; data_be = 0; mem_rdata = 0;
    model_reset();
    @(negedge clk);
    step(); step();
    rst = 0;
    #1;
    check("rst_addr", mem_addr, 32'h0);
    check("rst_we", mem_we, 32'h0);
    check("rst_be", mem_be, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);

    // 1: single fetch, zero-wait memory
    fetch_req = 1; fetch_addr = 32'h100;
    step();
    mem_ack = 1; mem_rdata = 32'h0000_0013;
    check("t1_addr", mem_addr, 32'h100);
    step();
    check("t1_ack", n_ack_f, 1);
    fetch_req = 0; mem_ack = 0;
    step();
    check("t1_idle", mem_req, 0);

    // 2: simultaneous requests, data store first
    grants.delete(); n_ack_f = 0; n_ack_d = 0;
    fetch_req = 1; fetch_addr = 32'h180;
    data_req = 1; data_we = 1; data_addr = 32'h200;
    data_wdata = 32'hDEADBEEF; data_be = 4'h3;
    for (int i = 0; i < 20; i++) begin
      mem_ack = m_busy; mem_rdata = $urandom;
      step();
      if (ack_d) data_req = 0;
      if (ack_f) fetch_req = 0;
    end
    mem_ack = 0;
    check("t2_ngrants", grants.size(), 2);
    if (grants.size() == 2) begin
      check("t2_first", grants[0], 1);
      check("t2_second", grants[1], 0);
    end
    check("t2_dacks", n_ack_d, 1);
    check("t2_facks", n_ack_f, 1);

    // 3/6: both held continuously
    grants.delete();
    fetch_req = 1; data_req = 1; data_we = 0;
`ifdef ZACORE_MEM_ARB_ROUND_ROBIN_EN
    exp3 = '{1, 0, 1, 0, 1, 0};
`else
    exp3 = '{1, 1, 1, 1, 0, 1};
`endif
    for (int i = 0; i < 40 && grants.size() < 6; i++) begin
      mem_ack = m_busy; mem_rdata = $urandom;
      step();
      if (ack_f) fetch_addr = fetch_addr + 4;
      if (ack_d) data_addr = data_addr + 4;
    end
    check("t3_ngrants", grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check($sformatf("t3_grant%0d", i), grants[i], exp3[i]);
    fetch_req = 0; data_req = 0; mem_ack = m_busy;
    step();
    mem_ack = m_busy;
    step();
    mem_ack = 0;
    step();

    // 4: fetch drops after grant, late memory ack
    n_ack_f = 0;
    fetch_req = 1; fetch_addr = 32'h300;
    step();
    fetch_req = 0;
    step(); step();
    mem_ack = 1;
    step();
    mem_ack = 0;
    check("t4_noack", n_ack_f, 0);
    fetch_req = 1; fetch_addr = 32'h340;
    step();
    check("t4_readdr", mem_addr, 32'h340);
    mem_ack = 1;
    step();
    check("t4_ack", n_ack_f, 1);
    fetch_req = 0; mem_ack = 0;
    step();

    // 5: reset while data transaction outstanding
    n_ack_d = 0;
    data_req = 1; data_we = 0; data_addr = 32'h400;
    step(); step();
    rst = 1;
    step();
    rst = 0; data_req = 0; mem_ack = 1;
    check("t5_req", mem_req, 0);
    step();
    mem_ack = 0;
    check("t5_noack", n_ack_d, 0);
    step();

    // Random traffic with stable fields while each request is high
    for (int i = 0; i < 4000; i++) begin
      if (!data_req || ack_d) begin
        drew = ($urandom_range(0, 2) != 0);
        data_req = drew;
        data_we = $urandom; data_addr = $urandom;
        data_wdata = $urandom; data_be = $urandom;
      end
      if (fetch_req && !ack_f && $urandom_range(0, 19) == 0) begin
        fetch_req = 0;
      end else if (!fetch_req || ack_f) begin
        fetch_req = ($urandom_range(0, 2) != 0);
        fetch_addr = {$urandom, 2'b00};
      end
      mem_ack = m_busy ? ($urandom_range(0, 2) == 0)
                       : ($urandom_range(0, 9) == 0);
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
